// File: rtl/serial_adder_pkg.sv
// Shared FSM encodings and sizing helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// DIGIT-bit combinational ripple adder reused every cycle by serial_adder.
module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
  end

  assign co    = c_s[DIGIT];
  // Carry into the top bit; paired with co it yields signed overflow.
  assign c_msb = c_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract, LSB first, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NUM = num_digits(WIDTH, DIGIT);
  localparam int CW  = cnt_width(NUM);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT-1:0] slice_s;
  logic             slice_co_s;
  logic             slice_c_msb_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             accept_s;
  logic             last_s;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_r[DIGIT-1:0]),
    .b     (b_r[DIGIT-1:0]),
    .cin   (carry_r),
    .s     (slice_s),
    .co    (slice_co_s),
    .c_msb (slice_c_msb_s)
  );

  // DONE accepts a new start just like IDLE, so back-to-back runs have no bubble.
  assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s     = (cnt_r == CW'(NUM - 1));
  assign sum_next_s = (sum >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

  // FSM, operand shift registers, result shift register and status flags.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept_s) begin
      state_r <= RUN;
      a_r     <= in1;
      b_r     <= sub ? ~in2 : in2;
      carry_r <= sub;
      cnt_r   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          sum     <= sum_next_s;
          carry_r <= slice_co_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            state_r  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cout     <= slice_co_s;
            overflow <= slice_c_msb_s ^ slice_co_s;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at DIGIT = 1, 4 and 8 (WIDTH = 8).
module tb_serial_adder;

  typedef struct packed {
    logic       cout;
    logic       ovf;
    logic [7:0] sum;
  } exp_t;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] in1 = 8'h00;
  logic [7:0] in2 = 8'h00;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  int sel = 0;
  logic       busy_m, done_m, cout_m, ovf_m;
  logic [7:0] sum_m;
  int         num_m;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .CLK(CLK), .reset(reset), .start(start), .sub(sub), .in1(in1), .in2(in2),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .CLK(CLK), .reset(reset), .start(start), .sub(sub), .in1(in1), .in2(in2),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4));
  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .CLK(CLK), .reset(reset), .start(start), .sub(sub), .in1(in1), .in2(in2),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));

  // Route the instance under test to one set of observation signals.
  always_comb begin
    busy_m = busy1; done_m = done1; sum_m = sum1; cout_m = cout1; ovf_m = ovf1; num_m = 8;
    case (sel)
      1: begin busy_m = busy4; done_m = done4; sum_m = sum4; cout_m = cout4; ovf_m = ovf4; num_m = 2; end
      2: begin busy_m = busy8; done_m = done8; sum_m = sum8; cout_m = cout8; ovf_m = ovf8; num_m = 1; end
      default: ;
    endcase
  end

  // Reference: full-width arithmetic, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    logic [8:0] r;
    if (s) r = {1'b0, a} - {1'b0, b};
    else   r = {1'b0, a} + {1'b0, b};
    e.sum  = r[7:0];
    e.cout = s ? (a >= b) : r[8];
    if (s) e.ovf = (a[7] != b[7]) && (r[7] != a[7]);
    else   e.ovf = (a[7] == b[7]) && (r[7] != a[7]);
    return e;
  endfunction

  task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input logic s);
    in1 = a; in2 = b; sub = s; start = 1'b1;
    exp_q.push_back(model(a, b, s));
  endtask

  // Step one edge at a time until done is seen; n counts edges from the start edge.
  task automatic wait_done(output int n, output int nbusy);
    n = 0; nbusy = 0;
    do begin
      @(posedge CLK); #1;
      n++;
      if (busy_m) nbusy++;
    end while (!done_m && n < 40);
    n_cmp++;
    if (!done_m) begin
      n_bad++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
  endtask

  task automatic check_result(input string name);
    exp_t e, got;
    got = {cout_m, ovf_m, sum_m};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: result with empty scoreboard, got %h", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got cout=%b ovf=%b sum=%h, expected cout=%b ovf=%b sum=%h",
                 name, got.cout, got.ovf, got.sum, e.cout, e.ovf, e.sum);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic s);
    int n, nb;
    @(posedge CLK); #1;
    drive_start(a, b, s);
    wait_done(n, nb);
    start = 1'b0;
    n_cmp++;
    if (n !== num_m + 1) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, n, num_m + 1);
    end
    n_cmp++;
    if (nb !== num_m) begin
      n_bad++;
      $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, nb, num_m);
    end
    check_result(name);
    @(posedge CLK); #1;
    n_cmp++;
    if (done_m !== 1'b0 || sum_m !== model(a, b, s).sum) begin
      n_bad++;
      $display("FAIL %s_after: done=%b sum=%h, expected done=0 sum=%h", name, done_m, sum_m, model(a, b, s).sum);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_state: got %h, expected 000", {busy1, done1, sum1, cout1, ovf1});
    end
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
  endtask

  task automatic test_add_sub();
    sel = 0;
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1);
    run_op("sub_equal", 8'h3C, 8'h3C, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic test_ignore_start();
    int n, nb;
    sel = 0;
    @(posedge CLK); #1;
    drive_start(8'h7F, 8'h01, 1'b0);
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    in1 = 8'h11; in2 = 8'h22; sub = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done(n, nb);
    check_result("ignore_start");
  endtask

  task automatic test_async_reset();
    int n, nb;
    sel = 0;
    @(posedge CLK); #1;
    drive_start(8'hAA, 8'h33, 1'b0);
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
      n_bad++;
      $display("FAIL async_reset: got %h, expected 000", {busy1, done1, sum1, cout1, ovf1});
    end
    exp_q.delete();
    @(posedge CLK); #1;
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (done1) nb++;
    end
    n_cmp++;
    if (nb !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d done pulses, expected 0", nb);
    end
    run_op("after_reset", 8'h12, 8'h34, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, nb;
    logic [7:0] a, b;
    sel = 0;
    @(posedge CLK); #1;
    drive_start(8'h01, 8'h02, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_done(n, nb);
      n_cmp++;
      if (n !== 9) begin
        n_bad++;
        $display("FAIL b2b_interval: got %0d, expected 9", n);
      end
      check_result("back_to_back");
      if (k < 3) begin
        a = 8'($urandom); b = 8'($urandom);
        drive_start(a, b, k[0]);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: done=%b busy=%b, expected 0 0", done1, busy1);
    end
  endtask

  task automatic test_digits();
    sel = 1;
    run_op("digit4_a5_5b", 8'hA5, 8'h5B, 1'b0);
    run_op("digit4_sub", 8'h80, 8'h01, 1'b1);
    sel = 2;
    run_op("digit8_7f_01", 8'h7F, 8'h01, 1'b0);
    run_op("digit8_sub", 8'h05, 8'h07, 1'b1);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_digits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
